mcu_bus_bridge: RTL and testbench
=================================

Name: mcu_bus_bridge

Overview:
- Parametrised bus bridge between the RV32I core's data bus and NUM_SLV memory-mapped peripherals.
- Successor to the direct core-to-RAM data bus: it adds address decoding, a two-phase APB-style handshake with slave wait states, and an error response for unmapped addresses.
- Sits inside the MCU top, between the core's bus port and the RAM/GPIO/UART/timer slaves.

Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width (multiple of 8)
- NUM_SLV, 4, number of slave channels (1..16)
- SLV_ADDR_W, 12, log2 of each slave window size in bytes
- BASE_ADDR, 32'h1000_0000, address of slave 0; slave i starts at BASE_ADDR + i<<SLV_ADDR_W
- TIMEOUT_CYC, 16, ACCESS-phase wait limit (used only with BUS_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- busReq  in  1  core request; held until busReady
- busWe  in  1  1 = write, 0 = read
- busAddr  in  ADDR_W  byte address
- busWData  in  DATA_W  write data
- Byte_Enable  in  DATA_W/8  write byte strobes
- busRData  out  DATA_W  read data, valid while busReady=1
- busReady  out  1  one-cycle completion pulse
- busErr  out  1  error flag, qualified by busReady
- PADDR  out  ADDR_W  latched address (full busAddr)
- PWDATA  out  DATA_W  latched write data
- PSTRB  out  DATA_W/8  latched strobes; all zero on reads
- PWRITE  out  1  latched busWe
- PSEL  out  NUM_SLV  one-hot slave select
- PENABLE  out  1  access phase
- PRDATA  in  NUM_SLV*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
- PREADY  in  NUM_SLV  slave ready

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs and internal latches clear to 0.
  - Takes effect mid-transaction: PSEL/PENABLE drop immediately, no busReady is issued, and the transaction is abandoned.
- Decode:
  - off = busAddr - BASE_ADDR (ADDR_W-bit unsigned); idx = off >> SLV_ADDR_W.
  - The address is mapped iff busAddr >= BASE_ADDR and idx < NUM_SLV.
- FSM states: IDLE, SETUP, ACCESS, DONE, ERR.
- IDLE:
  - On busReq=1 at an edge, latch busAddr, busWData, Byte_Enable (forced to 0 when busWe=0), busWe and idx.
  - Mapped address -> SETUP; unmapped -> ERR.
  - busReq=0 -> stay in IDLE.
- SETUP: PSEL[idx]=1, PENABLE=0, for exactly one cycle -> ACCESS.
- ACCESS:
  - PSEL[idx]=1, PENABLE=1.
  - On PREADY[idx]=1: register PRDATA[idx] into busRData (reads only; writes leave busRData at 0) -> DONE.
  - Otherwise stay in ACCESS.
  - PREADY of unselected slaves is ignored.
- DONE: busReady=1, busErr=0, PSEL=0, PENABLE=0, for one cycle -> IDLE. busRData returns to 0 on leaving DONE.
- ERR: busReady=1, busErr=1, busRData=0, no PSEL asserted, for one cycle -> IDLE.
- Latency:
  - With busReq sampled at edge k and zero slave wait states, busReady is high during the cycle after edge k+2.
  - Each wait cycle adds one cycle.
  - Unmapped access: busReady is high during the cycle after edge k.
- Handshake rules:
  - busReq is sampled only in IDLE; the bus inputs may change after latching without effect.
  - busReq still high during DONE/ERR is not treated as a new request; the next request is sampled in IDLE.
  - Back-to-back transactions are therefore separated by one IDLE cycle.
- Outputs are driven from registered state only: no combinational path from bus inputs to P* outputs or busReady.
- Wrap-around: busAddr below BASE_ADDR gives a large off and so decodes as unmapped; there is no aliasing.

Optional Feature:
- Macro: BUS_TIMEOUT_EN
- Defined:
  - A wait counter clears on entering ACCESS and increments each ACCESS cycle with PREADY[idx]=0.
  - When the count reaches TIMEOUT_CYC, the FSM goes to ERR (busErr=1, busRData=0), drops PSEL/PENABLE, and the late PREADY is ignored.
  - PREADY arriving on the same edge the limit is reached wins: normal DONE.
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

Test Plan:
- Zero-wait read: BASE_ADDR=0x1000_0000, slave 1 PRDATA=0xDEAD_BEEF with PREADY=1, read of 0x1000_1004 -> PSEL=4'b0010; SETUP then ACCESS; busReady with busRData=0xDEAD_BEEF and busErr=0 three cycles after the request; PADDR=0x1000_1004.
- Write with strobes: write 0x1122_3344 to 0x1000_3000 with Byte_Enable=4'b0011 and PREADY[3] delayed 3 cycles -> PSEL=4'b1000, PWRITE=1, PSTRB=0011, PWDATA=0x1122_3344; ACCESS held 4 cycles; busReady 6 cycles after the request; busRData=0.
- Unmapped: read of 0x1000_4000 and of 0x0FFF_FFFC -> no PSEL; busReady=1 with busErr=1 in the next cycle; busRData=0.
- Reset mid-ACCESS: assert reset=0 while PREADY=0 in ACCESS -> PSEL=0, PENABLE=0, busReady=0 immediately; after release, IDLE and a new read completes normally.
- Back-to-back: busReq held high across two reads to slaves 0 and 2 -> exactly one busReady per transaction, one IDLE cycle between them, PSEL never multi-hot.
- BUS_TIMEOUT_EN with TIMEOUT_CYC=16: slave never ready -> ERR after 16 ACCESS cycles, busErr=1; a variant with PREADY on the 16th cycle -> normal completion with busErr=0.

Source files
------------

// File: rtl/mcu_bus_bridge.sv
// mcu_bus_bridge: bridges the RV32I core data bus to NUM_SLV APB-style
// peripherals. Decodes the address into a one-hot slave select, runs a
// SETUP/ACCESS handshake honouring slave wait states, and answers
// unmapped addresses with a one-cycle error response.
// Optional build macro BUS_TIMEOUT_EN: bounds the ACCESS phase to
// TIMEOUT_CYC wait cycles and turns an expired wait into an error response.
module mcu_bus_bridge #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_SLV     = 4,
    parameter int                SLV_ADDR_W  = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
    parameter int                TIMEOUT_CYC = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      busReq,
    input  logic                      busWe,
    input  logic [ADDR_W-1:0]         busAddr,
    input  logic [DATA_W-1:0]         busWData,
    input  logic [DATA_W/8-1:0]       Byte_Enable,
    output logic [DATA_W-1:0]         busRData,
    output logic                      busReady,
    output logic                      busErr,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [DATA_W/8-1:0]       PSTRB,
    output logic                      PWRITE,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DONE, ERR} state_t;

    state_t state;

    // Address decode. Subtraction wraps, so addresses below BASE_ADDR give a
    // huge index; the explicit >= test keeps them unmapped as well.
    logic [ADDR_W-1:0]  decOff;
    logic [ADDR_W-1:0]  decIdx;
    logic               decInRange;
    logic [NUM_SLV-1:0] decSel;

    assign decOff     = busAddr - BASE_ADDR;
    assign decIdx     = decOff >> SLV_ADDR_W;
    assign decInRange = (busAddr >= BASE_ADDR) && (decIdx < ADDR_W'(NUM_SLV));

    // The latched slave index is kept in one-hot form as PSEL itself, so the
    // response mux below is a masked OR instead of a variable part-select.
    logic [DATA_W-1:0]  rdMasked [NUM_SLV];
    logic [DATA_W-1:0]  selRData;
    logic               selReady;

    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : gSlave
        assign decSel[gi]   = decInRange && (decIdx == ADDR_W'(gi));
        assign rdMasked[gi] = PSEL[gi] ? PRDATA[gi*DATA_W +: DATA_W] : '0;
    end

    // Only the selected slave's ready counts; others are masked out by PSEL.
    assign selReady = |(PREADY & PSEL);

    // OR-reduce the masked slave read data (at most one term is non-zero).
    always_comb begin
        selRData = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            selRData = selRData | rdMasked[i];
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] waitCnt;
`endif

    // Bridge FSM; every bus-side and P* output is a register written here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            PADDR    <= '0;
            PWDATA   <= '0;
            PSTRB    <= '0;
            PWRITE   <= 1'b0;
            PSEL     <= '0;
            PENABLE  <= 1'b0;
            busRData <= '0;
            busReady <= 1'b0;
            busErr   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            waitCnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (busReq) begin
                        PADDR  <= busAddr;
                        PWDATA <= busWData;
                        PSTRB  <= busWe ? Byte_Enable : '0;
                        PWRITE <= busWe;
                        if (|decSel) begin
                            PSEL  <= decSel;
                            state <= SETUP;
                        end else begin
                            busReady <= 1'b1;
                            busErr   <= 1'b1;
                            state    <= ERR;
                        end
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
`ifdef BUS_TIMEOUT_EN
                    waitCnt <= '0;
`endif
                end
                ACCESS: begin
                    if (selReady) begin
                        PSEL     <= '0;
                        PENABLE  <= 1'b0;
                        busReady <= 1'b1;
                        busErr   <= 1'b0;
                        busRData <= PWRITE ? '0 : selRData;
                        state    <= DONE;
                    end
`ifdef BUS_TIMEOUT_EN
                    // This edge would bring the count to TIMEOUT_CYC: give up.
                    else if (waitCnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        PSEL     <= '0;
                        PENABLE  <= 1'b0;
                        busReady <= 1'b1;
                        busErr   <= 1'b1;
                        busRData <= '0;
                        state    <= ERR;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
`endif
                end
                DONE, ERR: begin
                    // busReq is deliberately ignored here; it is re-sampled in IDLE.
                    busReady <= 1'b0;
                    busErr   <= 1'b0;
                    busRData <= '0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_bus_bridge.sv
// tb_mcu_bus_bridge: directed, table-driven bench for mcu_bus_bridge with
// hand-written sequences for reset mid-transaction and back-to-back requests.
module tb_mcu_bus_bridge;

    logic         clk = 1'b0;
    logic         reset;
    logic         busReq;
    logic         busWe;
    logic [31:0]  busAddr;
    logic [31:0]  busWData;
    logic [3:0]   Byte_Enable;
    logic [31:0]  busRData;
    logic         busReady;
    logic         busErr;
    logic [31:0]  PADDR;
    logic [31:0]  PWDATA;
    logic [3:0]   PSTRB;
    logic         PWRITE;
    logic [3:0]   PSEL;
    logic         PENABLE;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Fixed slave read data: slave 1 returns DEADBEEF, others A0A0_000i.
    assign PRDATA = {32'hA0A0_0003, 32'hA0A0_0002, 32'hDEAD_BEEF, 32'hA0A0_0000};

    mcu_bus_bridge dut (
        .clk(clk), .reset(reset),
        .busReq(busReq), .busWe(busWe), .busAddr(busAddr),
        .busWData(busWData), .Byte_Enable(Byte_Enable),
        .busRData(busRData), .busReady(busReady), .busErr(busErr),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waitN;     // ACCESS cycles before the slave answers
        logic [3:0]  expPsel;
        logic [3:0]  expStrb;
        logic        expErr;
        logic [31:0] expRData;
        int          expLat;    // edges from request to busReady visible
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic checkOneHot(input string nm);
        checks++;
        if ($countones(PSEL) > 1) begin
            errors++;
            $display("FAIL %s: PSEL multi-hot got %b expected at most one bit", nm, PSEL);
        end
    endtask

    task automatic runTxn(input vec_t v, input int id);
        int  cyc = 0;
        int  acc = 0;
        bit  got = 0;
        busReq      = 1'b1;
        busWe       = v.we;
        busAddr     = v.addr;
        busWData    = v.wdata;
        Byte_Enable = v.be;
        PREADY      = ~v.expPsel;
        while (!got && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                check($sformatf("v%0d psel", id), {28'd0, PSEL}, {28'd0, v.expPsel});
                check($sformatf("v%0d penable_setup", id), {31'd0, PENABLE}, 32'd0);
                check($sformatf("v%0d paddr", id), PADDR, v.addr);
                check($sformatf("v%0d pwrite", id), {31'd0, PWRITE}, {31'd0, v.we});
                check($sformatf("v%0d pstrb", id), {28'd0, PSTRB}, {28'd0, v.expStrb});
                check($sformatf("v%0d pwdata", id), PWDATA, v.wdata);
                // Bus inputs may now change without effect.
                busWe       = ~v.we;
                busAddr     = ~v.addr;
                busWData    = ~v.wdata;
                Byte_Enable = ~v.be;
            end
            checkOneHot($sformatf("v%0d onehot", id));
            if (PENABLE) acc++;
            PREADY = (PENABLE && acc > v.waitN) ? 4'hF : ~v.expPsel;
            if (busReady) begin
                got = 1;
                $display("txn v%0d: we=%0b addr=%h lat=%0d err=%0b rdata=%h",
                         id, v.we, v.addr, cyc, busErr, busRData);
                check($sformatf("v%0d latency", id), cyc, v.expLat);
                check($sformatf("v%0d err", id), {31'd0, busErr}, {31'd0, v.expErr});
                check($sformatf("v%0d rdata", id), busRData, v.expRData);
                check($sformatf("v%0d psel_end", id), {28'd0, PSEL}, 32'd0);
                check($sformatf("v%0d penable_end", id), {31'd0, PENABLE}, 32'd0);
            end
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL v%0d timeout: got no busReady expected one within 40 cycles", id);
        end
        busReq = 1'b0;
        PREADY = 4'h0;
        @(posedge clk); #1;
        check($sformatf("v%0d ready_after", id), {31'd0, busReady}, 32'd0);
        check($sformatf("v%0d rdata_after", id), busRData, 32'd0);
        check($sformatf("v%0d err_after", id), {31'd0, busErr}, 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        int rdyCnt;
        int firstAt;
        int secondAt;

        //          we    addr           wdata          be     wt  psel   strb   err   rdata          lat
        vecs.push_back('{1'b0, 32'h1000_1004, 32'h0,         4'hF, 0, 4'b0010, 4'h0, 1'b0, 32'hDEAD_BEEF, 3});
        vecs.push_back('{1'b1, 32'h1000_3000, 32'h1122_3344, 4'h3, 3, 4'b1000, 4'h3, 1'b0, 32'h0,         6});
        vecs.push_back('{1'b0, 32'h1000_4000, 32'h0,         4'hF, 0, 4'b0000, 4'h0, 1'b1, 32'h0,         1});
        vecs.push_back('{1'b0, 32'h0FFF_FFFC, 32'h0,         4'hF, 0, 4'b0000, 4'h0, 1'b1, 32'h0,         1});
        vecs.push_back('{1'b0, 32'h1000_0FFC, 32'h5555_0000, 4'h0, 1, 4'b0001, 4'h0, 1'b0, 32'hA0A0_0000, 4});
        vecs.push_back('{1'b1, 32'h1000_2008, 32'hCAFE_F00D, 4'hF, 0, 4'b0100, 4'hF, 1'b0, 32'h0,         3});
        vecs.push_back('{1'b0, 32'h1000_3FFC, 32'h0,         4'h0, 2, 4'b1000, 4'h0, 1'b0, 32'hA0A0_0003, 5});
        vecs.push_back('{1'b1, 32'h1000_4004, 32'h0BAD_0BAD, 4'h5, 0, 4'b0000, 4'h5, 1'b1, 32'h0,         1});
        vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 0, 4'b0000, 4'h0, 1'b1, 32'h0,         1});
`ifdef BUS_TIMEOUT_EN
        vecs.push_back('{1'b0, 32'h1000_1000, 32'h0,         4'h0, 100, 4'b0010, 4'h0, 1'b1, 32'h0,        18});
        vecs.push_back('{1'b0, 32'h1000_1000, 32'h0,         4'h0, 15,  4'b0010, 4'h0, 1'b0, 32'hDEAD_BEEF, 18});
`else
        vecs.push_back('{1'b0, 32'h1000_2000, 32'h0,         4'h0, 20,  4'b0100, 4'h0, 1'b0, 32'hA0A0_0002, 23});
`endif

        reset = 1'b0;
        busReq = 1'b0; busWe = 1'b0; busAddr = '0; busWData = '0;
        Byte_Enable = '0; PREADY = '0;
        @(posedge clk); @(posedge clk); #1;
        check("rst psel", {28'd0, PSEL}, 32'd0);
        check("rst penable", {31'd0, PENABLE}, 32'd0);
        check("rst ready", {31'd0, busReady}, 32'd0);
        check("rst err", {31'd0, busErr}, 32'd0);
        check("rst rdata", busRData, 32'd0);
        check("rst paddr", PADDR, 32'd0);
        check("rst pstrb", {28'd0, PSTRB}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) runTxn(vecs[i], i);

        // Reset asserted mid-ACCESS with the slave stalling.
        busReq = 1'b1; busWe = 1'b0; busAddr = 32'h1000_2010; PREADY = 4'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstmid in_access", {31'd0, PENABLE}, 32'd1);
        check("rstmid psel_before", {28'd0, PSEL}, 32'h4);
        reset = 1'b0;
        busReq = 1'b0;
        #1;
        check("rstmid psel", {28'd0, PSEL}, 32'd0);
        check("rstmid penable", {31'd0, PENABLE}, 32'd0);
        check("rstmid ready", {31'd0, busReady}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        check("rstmid ready_held", {31'd0, busReady}, 32'd0);
        reset = 1'b1;
        $display("txn reset mid-access: bridge returned to idle");
        runTxn(vecs[0], 100);

        // Back-to-back reads with busReq held high throughout.
        busReq = 1'b1; busWe = 1'b0; busAddr = 32'h1000_0010; PREADY = 4'hF;
        rdyCnt = 0; firstAt = 0; secondAt = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            checkOneHot("b2b onehot");
            if (c == firstAt + 1 && firstAt != 0) begin
                check("b2b idle_gap_psel", {28'd0, PSEL}, 32'd0);
                check("b2b idle_gap_ready", {31'd0, busReady}, 32'd0);
            end
            if (c == firstAt + 2 && firstAt != 0)
                check("b2b second_psel", {28'd0, PSEL}, 32'h4);
            if (busReady) begin
                rdyCnt++;
                if (rdyCnt == 1) begin
                    firstAt = c;
                    check("b2b rdata0", busRData, 32'hA0A0_0000);
                    busAddr = 32'h1000_2020;
                end else if (rdyCnt == 2) begin
                    secondAt = c;
                    check("b2b rdata2", busRData, 32'hA0A0_0002);
                    busReq = 1'b0;
                end
                $display("txn b2b #%0d: cycle=%0d rdata=%h err=%0b", rdyCnt, c, busRData, busErr);
            end
        end
        PREADY = 4'h0;
        check("b2b ready_count", rdyCnt, 2);
        check("b2b first_at", firstAt, 3);
        check("b2b second_at", secondAt, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
